// File: rtl/period_meter.sv
// Period meter: measures the rising-edge-to-rising-edge period of an asynchronous input
// in clock_in cycles, flagging a sticky timeout when no edge arrives in time.
module period_meter #(
    parameter int unsigned NUM_BITS = 26,
    parameter int unsigned TIMEOUT  = 50_000_000
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic                enable,
    input  logic                signal_in,
    output logic [NUM_BITS-1:0] period_out,
    output logic                valid,
    output logic                timeout,
    output logic                busy
);

    localparam logic [NUM_BITS-1:0] TimeoutCount = NUM_BITS'(TIMEOUT);
    localparam logic [NUM_BITS-1:0] CountOne     = NUM_BITS'(1);

    typedef enum logic {
        StWaitEdge,
        StMeasure
    } state_e;

    state_e              state_q, state_d;
    logic                s1_q, s2_q, s3_q;
    logic                edge_det;
    logic [NUM_BITS-1:0] count_q, count_d;
    logic [NUM_BITS-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;

    // Synchronizer and delay flop keep running regardless of enable.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= signal_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_det = s2_q & ~s3_q;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q   <= StWaitEdge;
            count_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!enable) begin
            state_d = StWaitEdge;
            count_d = '0;
        end else begin
            case (state_q)
                StWaitEdge: begin
                    if (edge_det) begin
                        state_d = StMeasure;
                        count_d = CountOne;
                    end else begin
                        count_d = '0;
                    end
                end
                StMeasure: begin
                    // An edge on the timeout cycle still counts as a measurement.
                    if (edge_det) begin
                        period_d  = count_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        count_d   = CountOne;
                    end else if (count_q == TimeoutCount) begin
                        timeout_d = 1'b1;
                        count_d   = '0;
                        state_d   = StWaitEdge;
                    end else begin
                        count_d = count_q + CountOne;
                    end
                end
                default: begin
                    state_d = StWaitEdge;
                    count_d = '0;
                end
            endcase
        end
    end

    assign period_out = period_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q == StMeasure);

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: a time-stamp model of edge arrivals checked every
// cycle, plus directed scenarios with literal expectations.
module tb_period_meter;

    localparam int unsigned NB = 8;
    localparam int unsigned TO = 100;
    localparam int          HI = 3;

    logic          clock_in;
    logic          reset;
    logic          enable;
    logic          signal_in;
    logic [NB-1:0] period_out;
    logic          valid;
    logic          timeout;
    logic          busy;

    period_meter #(
        .NUM_BITS(NB),
        .TIMEOUT (TO)
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (enable),
        .signal_in (signal_in),
        .period_out(period_out),
        .valid     (valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    // Model: an edge of signal_in sampled at clock k is seen at clock k+2; the period is
    // the difference of the clock indices at which consecutive edges are seen.
    int m_cyc     = 0;
    int m_start   = 0;
    int m_period  = 0;
    int m_valid   = 0;
    int m_timeout = 0;
    int m_busy    = 0;
    bit m_hist[$] = '{1'b0, 1'b0, 1'b0};

    initial begin
        bit m_edge;
        forever begin
            @(posedge clock_in or posedge reset);
            if (reset) begin
                m_period  = 0;
                m_valid   = 0;
                m_timeout = 0;
                m_busy    = 0;
                m_hist    = '{1'b0, 1'b0, 1'b0};
            end else begin
                m_cyc++;
                m_edge  = m_hist[1] && !m_hist[0];
                m_valid = 0;
                if (!enable) begin
                    m_busy = 0;
                end else if (m_edge) begin
                    if (m_busy != 0) begin
                        m_period  = m_cyc - m_start;
                        m_valid   = 1;
                        m_timeout = 0;
                    end
                    m_busy  = 1;
                    m_start = m_cyc;
                end else if (m_busy != 0 && (m_cyc - m_start) == int'(TO)) begin
                    m_timeout = 1;
                    m_busy    = 0;
                end
                void'(m_hist.pop_front());
                m_hist.push_back(signal_in);
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;
    int vq[$];
    int mark;

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic int vq_at(int idx);
        if (idx < vq.size()) return vq[idx];
        return -1;
    endfunction

    task automatic cyc();
        @(negedge clock_in);
        chk("model_period_out", int'(period_out), m_period);
        chk("model_valid", int'(valid), m_valid);
        chk("model_timeout", int'(timeout), m_timeout);
        chk("model_busy", int'(busy), m_busy);
        if (valid) vq.push_back(int'(period_out));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Rising edge now, next rising edge of the following call exactly n cycles later.
    task automatic pulse_then_wait(int n);
        signal_in = 1'b1;
        idle(HI);
        signal_in = 1'b0;
        idle(n - HI);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        signal_in = 1'b0;
        #1;
        chk("reset_period_out", int'(period_out), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_timeout", int'(timeout), 0);
        chk("reset_busy", int'(busy), 0);
        idle(2);
        reset  = 1'b0;
        enable = 1'b1;
        idle(3);

        // Steady 10-cycle period: first edge only starts, then five results of 10.
        mark = vq.size();
        for (int i = 0; i < 6; i++) pulse_then_wait(10);
        chk("p10_count", vq.size() - mark, 5);
        for (int i = 0; i < 5; i++) chk("p10_value", vq_at(mark + i), 10);
        chk("p10_busy", int'(busy), 1);
        chk("p10_timeout", int'(timeout), 0);
        idle(120);
        chk("p10_to_timeout", int'(timeout), 1);
        chk("p10_to_busy", int'(busy), 0);
        chk("p10_to_period", int'(period_out), 10);

        // 40-cycle period followed by silence.
        mark = vq.size();
        pulse_then_wait(40);
        pulse_then_wait(40);
        chk("p40_count", vq.size() - mark, 1);
        chk("p40_value", vq_at(mark), 40);
        chk("p40_timeout_cleared", int'(timeout), 0);
        idle(70);
        chk("p40_to_timeout", int'(timeout), 1);
        chk("p40_to_busy", int'(busy), 0);
        chk("p40_to_period", int'(period_out), 40);

        // Boundary: 100 cycles measures, 101 cycles times out.
        mark = vq.size();
        pulse_then_wait(100);
        pulse_then_wait(5);
        chk("p100_count", vq.size() - mark, 1);
        chk("p100_value", vq_at(mark), 100);
        chk("p100_timeout", int'(timeout), 0);
        idle(96);
        pulse_then_wait(5);
        chk("p101_count", vq.size() - mark, 1);
        chk("p101_timeout", int'(timeout), 1);
        chk("p101_busy", int'(busy), 1);
        chk("p101_period", int'(period_out), 100);
        idle(120);

        // Asynchronous reset 20 cycles into a measurement.
        mark = vq.size();
        pulse_then_wait(20);
        #2 reset = 1'b1;
        #1;
        chk("arst_period_out", int'(period_out), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_timeout", int'(timeout), 0);
        chk("arst_busy", int'(busy), 0);
        cyc();
        reset = 1'b0;
        pulse_then_wait(50);
        pulse_then_wait(5);
        chk("arst_count", vq.size() - mark, 1);
        chk("arst_value", vq_at(mark), 50);
        idle(120);

        // enable dropped for 5 cycles mid-measurement.
        pulse_then_wait(30);
        pulse_then_wait(10);
        enable = 1'b0;
        cyc();
        chk("en_off_busy", int'(busy), 0);
        chk("en_off_period", int'(period_out), 30);
        idle(4);
        enable = 1'b1;
        mark = vq.size();
        pulse_then_wait(12);
        pulse_then_wait(5);
        chk("en_on_count", vq.size() - mark, 1);
        chk("en_on_value", vq_at(mark), 12);
        idle(120);

        // Alternating 7/13 periods.
        mark = vq.size();
        pulse_then_wait(7);
        pulse_then_wait(13);
        pulse_then_wait(7);
        pulse_then_wait(13);
        pulse_then_wait(5);
        chk("alt_count", vq.size() - mark, 4);
        chk("alt_0", vq_at(mark), 7);
        chk("alt_1", vq_at(mark + 1), 13);
        chk("alt_2", vq_at(mark + 2), 7);
        chk("alt_3", vq_at(mark + 3), 13);
        idle(120);

        // Latency from first s1 sample to valid.
        pulse_then_wait(20);
        signal_in = 1'b1;
        cyc();
        chk("lat_c1_valid", int'(valid), 0);
        cyc();
        chk("lat_c2_valid", int'(valid), 0);
        cyc();
        chk("lat_c3_valid", int'(valid), 1);
        chk("lat_period", int'(period_out), 20);
        cyc();
        chk("lat_c4_valid", int'(valid), 0);
        signal_in = 1'b0;
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 26, meaning the width of the period counter and period_out.
REQ-002 The block SHALL have parameter TIMEOUT, default 50_000_000, meaning the maximum measurable period in clock_in cycles; it SHALL satisfy 2 <= TIMEOUT < 2**NUM_BITS.
REQ-003 The block SHALL have port clock_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: measurement enable.
REQ-006 The block SHALL have port signal_in, input, 1 bit: asynchronous pulse or clock whose rising-edge-to-rising-edge period is measured.
REQ-007 The block SHALL have port period_out, output, NUM_BITS bits: last completed period, in clock_in cycles.
REQ-008 The block SHALL have port valid, output, 1 bit: one-cycle pulse when period_out is updated.
REQ-009 The block SHALL have port timeout, output, 1 bit: sticky flag indicating no edge arrived within TIMEOUT cycles.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in state MEASURE.

Function
REQ-011 signal_in SHALL pass through a 2-flop synchronizer (s1, s2) followed by a delay flop s3; edge = s2 AND NOT s3.
REQ-012 The FSM SHALL have two states: WAIT_EDGE and MEASURE. busy SHALL equal (state == MEASURE), registered.
REQ-013 In WAIT_EDGE with enable = 1 and edge = 1, the FSM SHALL go to MEASURE with count <= 1; otherwise count SHALL hold 0.
REQ-014 In MEASURE without edge and with count < TIMEOUT, the block SHALL set count <= count + 1.
REQ-015 In MEASURE with edge = 1, the block SHALL set period_out <= count, valid <= 1 for exactly one cycle, timeout <= 0, and count <= 1, and SHALL remain in MEASURE (back-to-back measurements, no dead cycle).
REQ-016 Edges separated by N clock_in cycles at the edge detector SHALL yield period_out = N, for 1 <= N <= TIMEOUT.
REQ-017 In MEASURE with no edge and count == TIMEOUT, the block SHALL set timeout <= 1, count <= 0, and state <= WAIT_EDGE; period_out SHALL hold its value and valid SHALL stay 0.
REQ-018 An edge and count == TIMEOUT in the same cycle SHALL be a valid measurement (edge wins): period_out = TIMEOUT, with no timeout.
REQ-019 timeout SHALL remain 1 until the next valid pulse or reset.
REQ-020 enable = 0 SHALL force state <= WAIT_EDGE and count <= 0, and hold valid at 0, on the next clock; period_out and timeout SHALL hold their values; synchronizer flops SHALL keep running.
REQ-021 After enable returns to 1, the first edge SHALL only start a measurement; the first valid pulse SHALL come on the second edge.
REQ-022 The latency from the clock that first samples signal_in = 1 into s1 to valid = 1 SHALL be 3 clock_in cycles.
REQ-023 count SHALL never exceed TIMEOUT and never wrap.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 reset = 1 SHALL immediately, independent of clock_in, clear s1, s2, s3, count, period_out, valid, timeout, and busy to 0, and force state to WAIT_EDGE.
REQ-026 Reset asserted mid-measurement SHALL discard the partial count; after release, the first edge SHALL produce no valid pulse.

Verification
REQ-027 TIMEOUT=100, enable=1, signal_in rising every 10 cycles -> from the 2nd edge onward, valid pulses every 10 cycles with period_out=10, busy=1, timeout=0.
REQ-028 TIMEOUT=100, edges 40 cycles apart and then no further edges -> period_out=40 with valid; 100 cycles after the last edge's count start, timeout=1, busy=0, period_out stays 40.
REQ-029 TIMEOUT=100, two edges exactly 100 cycles apart -> valid with period_out=100 and timeout=0; edges 101 cycles apart -> timeout=1 and no valid.
REQ-030 Reset pulse 20 cycles into a 50-cycle period -> all outputs 0 asynchronously; the next edge gives no valid; the following edge gives period_out=50.
REQ-031 enable dropped for 5 cycles during MEASURE -> busy=0 and period_out held; after re-enable, the first valid pulse comes only on the second edge.
REQ-032 Period alternating 7/13 cycles -> period_out sequence 7,13,7,13 with a 1-cycle valid each and no missed edges.
